// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned WORD_SEL_W = 2;
  localparam int unsigned OFFSET_W   = 3;
  // Widest tag (SETS = 2); narrower tags are zero-extended into this field.
  localparam int unsigned TAG_MAX_W  = ADDR_W - OFFSET_W - 1;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StEvict,
    StFill,
    StFinish
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int unsigned index_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  // Rebuild a memory byte address from its cache fields.
  function automatic logic [ADDR_W-1:0] word_addr(logic [TAG_MAX_W-1:0]  tag,
                                                  logic [TAG_MAX_W-1:0]  idx,
                                                  logic [WORD_SEL_W-1:0] word,
                                                  int unsigned           idx_bits);
    return (ADDR_W'(tag) << (OFFSET_W + idx_bits)) | (ADDR_W'(idx) << OFFSET_W) |
           (ADDR_W'(word) << 1);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: tag/valid/dirty/data with one write port and asynchronous read.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [index_w(SETS)-1:0]             rd_idx,
  output line_meta_t                           rd_meta,
  output logic [WORDS-1:0][DATA_W-1:0]         rd_line,
  input  logic                                 we_word,
  input  logic                                 we_meta,
  input  logic [index_w(SETS)-1:0]             wr_idx,
  input  logic [WORD_SEL_W-1:0]                wr_word,
  input  logic [DATA_W-1:0]                    wr_data,
  input  line_meta_t                           wr_meta
);

  logic [SETS-1:0]              valid_q;
  logic [SETS-1:0]              dirty_q;
  logic [TAG_MAX_W-1:0]         tag_q  [SETS];
  logic [WORDS-1:0][DATA_W-1:0] data_q [SETS];

  // Only the status bits need clearing; tags and data are qualified by valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_meta) begin
      valid_q[wr_idx] <= wr_meta.valid;
      dirty_q[wr_idx] <= wr_meta.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we_meta) begin
      tag_q[wr_idx] <= wr_meta.tag;
    end
    if (we_word) begin
      data_q[wr_idx][wr_word] <= wr_data;
    end
  end

  assign rd_meta = '{valid: valid_q[rd_idx], dirty: dirty_q[rd_idx], tag: tag_q[rd_idx]};
  assign rd_line = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned SETS    = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
`ifdef DCACHE_STATS_EN
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
`endif
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned IDX_W = index_w(SETS);
  localparam int unsigned QW    = $clog2(MEM_LAT + 1);

  state_e                  state_q, state_d;
  logic                    req_wr_q;
  logic [WORD_SEL_W-1:0]   req_word_q;
  logic [IDX_W-1:0]        req_idx_q;
  logic [TAG_MAX_W-1:0]    req_tag_q;
  logic [DATA_W-1:0]       req_data_q;
  logic [2:0]              xfer_q, xfer_d;
  logic [1:0]              rx_q, rx_d;
  logic [QW-1:0]           quiet_q;
  logic                    err_q, err_d;
  logic                    latch_req;

  line_meta_t                   meta;
  logic [WORDS-1:0][DATA_W-1:0] line;
  logic                         we_word, we_meta;
  logic [WORD_SEL_W-1:0]        wr_word;
  logic [DATA_W-1:0]            wr_data;
  line_meta_t                   wr_meta;

  logic hit, quiet, extra_rx, rx_take;

  dcache_array #(
    .SETS(SETS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (req_idx_q),
    .rd_meta(meta),
    .rd_line(line),
    .we_word(we_word),
    .we_meta(we_meta),
    .wr_idx (req_idx_q),
    .wr_word(wr_word),
    .wr_data(wr_data),
    .wr_meta(wr_meta)
  );

  assign hit      = meta.valid && (meta.tag == req_tag_q);
  // Returns still in flight from before a reset land inside this window and are dropped.
  assign quiet    = quiet_q < QW'(MEM_LAT);
  assign extra_rx = {1'b0, rx_q} >= xfer_q;
  assign rx_take  = mem_rvalid && !quiet && (state_q == StFill) && !extra_rx;

  always_comb begin
    state_d   = state_q;
    xfer_d    = xfer_q;
    rx_d      = rx_q;
    latch_req = 1'b0;
    err_d     = mem_rvalid && !quiet && !rx_take;
    Done      = 1'b0;
    CacheHit  = 1'b0;
    we_word   = 1'b0;
    we_meta   = 1'b0;
    wr_word   = req_word_q;
    wr_data   = req_data_q;
    wr_meta   = '{valid: 1'b1, dirty: 1'b1, tag: req_tag_q};
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (Rd && Wr) begin
          err_d = 1'b1;
        end else if (Rd || Wr) begin
          if (Addr[0]) begin
            err_d = 1'b1;
          end else begin
            latch_req = 1'b1;
            state_d   = StCompare;
          end
        end
      end
      StCompare: begin
        xfer_d = '0;
        rx_d   = '0;
        if (hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          we_word  = req_wr_q;
          we_meta  = req_wr_q;
          state_d  = StIdle;
        end else if (meta.valid && meta.dirty) begin
          state_d = StEvict;
        end else begin
          state_d = StFill;
        end
      end
      StEvict: begin
        mem_wr    = 1'b1;
        mem_addr  = word_addr(meta.tag, TAG_MAX_W'(req_idx_q), xfer_q[1:0], IDX_W);
        mem_wdata = line[xfer_q[1:0]];
        if (!mem_stall) begin
          if (xfer_q == 3'd3) begin
            xfer_d  = '0;
            state_d = StFill;
          end else begin
            xfer_d = xfer_q + 3'd1;
          end
        end
      end
      StFill: begin
        if (!xfer_q[2]) begin
          mem_rd   = 1'b1;
          mem_addr = word_addr(req_tag_q, TAG_MAX_W'(req_idx_q), xfer_q[1:0], IDX_W);
          if (!mem_stall) begin
            xfer_d = xfer_q + 3'd1;
          end
        end
        if (rx_take) begin
          we_word = 1'b1;
          wr_word = rx_q;
          wr_data = mem_rdata;
          rx_d    = rx_q + 2'd1;
          if (rx_q == 2'd3) begin
            we_meta = 1'b1;
            wr_meta = '{valid: 1'b1, dirty: 1'b0, tag: req_tag_q};
            xfer_d  = '0;
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        Done    = 1'b1;
        we_word = req_wr_q;
        we_meta = req_wr_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign DataOut = Done ? line[req_word_q] : '0;
  assign Stall   = (state_q != StIdle) && !Done;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      xfer_q     <= '0;
      rx_q       <= '0;
      err_q      <= 1'b0;
      quiet_q    <= '0;
      req_wr_q   <= 1'b0;
      req_word_q <= '0;
      req_idx_q  <= '0;
      req_tag_q  <= '0;
      req_data_q <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      if (quiet) begin
        quiet_q <= quiet_q + QW'(1);
      end
      if (latch_req) begin
        req_wr_q   <= Wr;
        req_word_q <= Addr[2:1];
        req_idx_q  <= Addr[OFFSET_W +: IDX_W];
        req_tag_q  <= TAG_MAX_W'(Addr >> (OFFSET_W + IDX_W));
        req_data_q <= DataIn;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (Done) begin
      if (CacheHit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a word-wide, 2-cycle-latency memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Rd = 1'b0, Wr = 1'b0;
  logic [15:0] Addr = '0, DataIn = '0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, mem_rd, mem_rvalid;
  logic        mem_stall = 1'b0;
  logic        mem_inj = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(
    .SETS   (32),
    .MEM_LAT(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rd        (Rd),
    .Wr        (Wr),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .err       (err),
`ifdef DCACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  // Memory model: unwritten words read back as a fixed function of their address.
  bit          written  [0:32767];
  logic [15:0] wdat_arr [0:32767];
  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [15:0] p0_d = '0, p1_d = '0;
  int          wr_acc = 0, rd_acc = 0, rv_cnt = 0;
  logic        both_seen = 1'b0;
  logic [15:0] wr_addr_log[$], wr_data_log[$], rd_addr_log[$];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h0101;
  endfunction

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return written[a[15:1]] ? wdat_arr[a[15:1]] : init_val({a[15:1], 1'b0});
  endfunction

  always @(posedge clk) begin
    if (mem_wr && !mem_stall) begin
      written[mem_addr[15:1]]  <= 1'b1;
      wdat_arr[mem_addr[15:1]] <= mem_wdata;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      wr_acc <= wr_acc + 1;
    end
    if (mem_rd && !mem_stall) begin
      rd_addr_log.push_back(mem_addr);
      rd_acc <= rd_acc + 1;
    end
    if (mem_rd && mem_wr) both_seen <= 1'b1;
    p0_v <= mem_rd && !mem_stall;
    p0_d <= mem_val(mem_addr);
    p1_v <= p0_v;
    p1_d <= p0_d;
    if (mem_rvalid) rv_cnt <= rv_cnt + 1;
  end

  assign mem_rvalid = p1_v | mem_inj;
  assign mem_rdata  = p1_d;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU access; optionally stalls memory for 3 cycles while write stall_idx is presented.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] din, input int stall_idx,
                           output int lat, output logic hit, output logic [15:0] data);
    int          wr_base = wr_acc;
    int          left = 0;
    bit          stalled = 0;
    logic [15:0] hold_a = '0, hold_d = '0;
    lat  = -1;
    hit  = 1'b0;
    data = '0;
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (left > 0) begin
        check("evict hold mem_wr", {31'd0, mem_wr}, 32'd1);
        check("evict hold mem_addr", {16'd0, mem_addr}, {16'd0, hold_a});
        check("evict hold mem_wdata", {16'd0, mem_wdata}, {16'd0, hold_d});
        left--;
        if (left == 0) mem_stall = 1'b0;
      end else if (stall_idx >= 0 && !stalled && mem_wr && (wr_acc - wr_base) == stall_idx) begin
        stalled   = 1;
        hold_a    = mem_addr;
        hold_d    = mem_wdata;
        mem_stall = 1'b1;
        left      = 3;
      end
      if (Done) begin
        lat  = c;
        hit  = CacheHit;
        data = DataOut;
        break;
      end
    end
    Rd = 1'b0; Wr = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic do_err(input logic rd, input logic wr, input logic [15:0] addr);
    int rb = rd_acc, wb = wr_acc;
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = addr;
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
    check("err pulse", {31'd0, err}, 32'd1);
    check("err no done", {31'd0, Done}, 32'd0);
    @(negedge clk);
    check("err one cycle", {31'd0, err}, 32'd0);
    check("err no stall", {31'd0, Stall}, 32'd0);
    check("err no mem traffic", rd_acc - rb + wr_acc - wb, 32'd0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_err;
    logic        exp_hit;
    int          exp_lat;
    logic        chk_data;
    logic [15:0] exp_data;
    int          exp_nwr;
    logic [15:0] wb_base;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          lat;
    logic        hit;
    logic [15:0] data;
    int          rb, rlog, wlog, wb;
    bit          err_seen;

    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        hit;
    logic [15:0] data;
    int          rb, rlog, wlog, wb;
    bit          err_seen;
    bit          got;

    vecs[0]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 8, 1'b1, init_val(16'h1234), 0, 16'h0};
    vecs[1]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b1, 1, 1'b1, init_val(16'h1234), 0, 16'h0};
    vecs[2]  = '{1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b1, 1, 1'b0, 16'h0000, 0, 16'h0};
    vecs[3]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b1, 1, 1'b1, 16'hBEEF, 0, 16'h0};
    vecs[4]  = '{1'b1, 1'b0, 16'h1236, 16'h0000, 1'b0, 1'b1, 1, 1'b1, init_val(16'h1236), 0, 16'h0};
    vecs[5]  = '{1'b1, 1'b0, 16'h5534, 16'h0000, 1'b0, 1'b0, 12, 1'b1, init_val(16'h5534), 4, 16'h1230};
    vecs[6]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 8, 1'b1, 16'hBEEF, 0, 16'h0};
    vecs[7]  = '{1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 0, 16'h0};
    vecs[8]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 0, 16'h0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0001, 16'h1234, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 0, 16'h0};
    vecs[10] = '{1'b0, 1'b1, 16'h00A0, 16'h1111, 1'b0, 1'b0, 8, 1'b0, 16'h0000, 0, 16'h0};
    vecs[11] = '{1'b1, 1'b0, 16'h00A0, 16'h0000, 1'b0, 1'b1, 1, 1'b1, 16'h1111, 0, 16'h0};
    vecs[12] = '{1'b1, 1'b0, 16'h00A6, 16'h0000, 1'b0, 1'b1, 1, 1'b1, init_val(16'h00A6), 0, 16'h0};

    // Reset state
    #2 rst = 1'b0;
    #2;
    check("reset Done", {31'd0, Done}, 32'd0);
    check("reset Stall", {31'd0, Stall}, 32'd0);
    check("reset CacheHit", {31'd0, CacheHit}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset mem_rd/mem_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("reset DataOut", {16'd0, DataOut}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].exp_err) begin
        do_err(vecs[i].rd, vecs[i].wr, vecs[i].addr);
      end else begin
        rb = rd_acc; rlog = rd_addr_log.size(); wb = wr_acc; wlog = wr_addr_log.size();
        do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, -1, lat, hit, data);
        check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        check($sformatf("vec%0d CacheHit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
        if (vecs[i].chk_data) check($sformatf("vec%0d DataOut", i), {16'd0, data},
                                    {16'd0, vecs[i].exp_data});
        check($sformatf("vec%0d reads", i), rd_acc - rb, vecs[i].exp_hit ? 0 : 4);
        if (!vecs[i].exp_hit) begin
          for (int k = 0; k < 4; k++)
            check($sformatf("vec%0d read addr %0d", i, k), {16'd0, rd_addr_log[rlog + k]},
                  {16'd0, (vecs[i].addr & 16'hFFF8) + 16'(2 * k)});
        end
        check($sformatf("vec%0d writes", i), wr_acc - wb, vecs[i].exp_nwr);
        for (int k = 0; k < vecs[i].exp_nwr; k++)
          check($sformatf("vec%0d write addr %0d", i, k), {16'd0, wr_addr_log[wlog + k]},
                {16'd0, vecs[i].wb_base + 16'(2 * k)});
        if (i == 5) check("evicted word2", {16'd0, wr_data_log[wlog + 2]}, 32'h0000BEEF);
      end
    end

    // Dirty eviction with memory refusing the second write for 3 cycles
    do_access(1'b0, 1'b1, 16'h00A2, 16'h2222, -1, lat, hit, data);
    check("A2 write hit", {31'd0, hit}, 32'd1);
    rb = rd_acc; wb = wr_acc; wlog = wr_addr_log.size();
    do_access(1'b1, 1'b0, 16'h77A0, 16'h0000, 1, lat, hit, data);
    check("stall evict latency", lat, 15);
    check("stall evict hit", {31'd0, hit}, 32'd0);
    check("stall evict data", {16'd0, data}, {16'd0, init_val(16'h77A0)});
    check("stall evict writes", wr_acc - wb, 4);
    check("stall evict reads", rd_acc - rb, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("stall wb addr %0d", k), {16'd0, wr_addr_log[wlog + k]},
            {16'd0, 16'h00A0 + 16'(2 * k)});
    check("stall wb data 0", {16'd0, wr_data_log[wlog]}, 32'h00001111);
    check("stall wb data 1", {16'd0, wr_data_log[wlog + 1]}, 32'h00002222);
    check("stall wb data 2", {16'd0, wr_data_log[wlog + 2]}, {16'd0, init_val(16'h00A4)});
    do_access(1'b1, 1'b0, 16'h00A2, 16'h0000, -1, lat, hit, data);
    check("refill A2 latency", lat, 8);
    check("refill A2 data", {16'd0, data}, 32'h00002222);

    // Return with no read outstanding
    @(negedge clk);
    mem_inj = 1'b1;
    @(negedge clk);
    mem_inj = 1'b0;
    check("spurious rvalid err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("spurious rvalid err clears", {31'd0, err}, 32'd0);

    // Reset in the middle of a fill after two returns
    rb = rv_cnt;
    got = 0;
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h3310;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rv_cnt - rb >= 2) begin
        got = 1;
        break;
      end
    end
    check("mid-fill reached", {31'd0, got}, 32'd1);
    check("mid-fill stalled", {31'd0, Stall}, 32'd1);
    rst = 1'b0;
    Rd  = 1'b0;
    #1;
    check("mid reset Done", {31'd0, Done}, 32'd0);
    check("mid reset Stall", {31'd0, Stall}, 32'd0);
    check("mid reset mem_rd", {31'd0, mem_rd}, 32'd0);
    check("mid reset mem_addr", {16'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    err_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (err) err_seen = 1;
    end
    check("stale rvalid no err", {31'd0, err_seen}, 32'd0);
    do_access(1'b1, 1'b0, 16'h3310, 16'h0000, -1, lat, hit, data);
    check("post reset miss", {31'd0, hit}, 32'd0);
    check("post reset latency", lat, 8);
    check("post reset data", {16'd0, data}, {16'd0, init_val(16'h3310)});

    // Three hits and a second miss since reset
    do_access(1'b1, 1'b0, 16'h3310, 16'h0000, -1, lat, hit, data);
    check("hit 1", {31'd0, hit}, 32'd1);
    do_access(1'b1, 1'b0, 16'h3312, 16'h0000, -1, lat, hit, data);
    check("hit 2 data", {16'd0, data}, {16'd0, init_val(16'h3312)});
    do_access(1'b1, 1'b0, 16'h3314, 16'h0000, -1, lat, hit, data);
    check("hit 3", {31'd0, hit}, 32'd1);
    do_access(1'b1, 1'b0, 16'h4410, 16'h0000, -1, lat, hit, data);
    check("conflict miss", {31'd0, hit}, 32'd0);
    check("conflict miss latency", lat, 8);
`ifdef DCACHE_STATS_EN
    check("hit_count", {16'd0, hit_count}, 32'd3);
    check("miss_count", {16'd0, miss_count}, 32'd2);
`endif

    check("mem_rd and mem_wr never together", {31'd0, both_seen}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
